tt_frame_tx: RTL and testbench
==============================

# tt_frame_tx

Serial frame transmitter for a TinyTapeout user slot. A 4-bit word and a parity mode are sampled from the input pins. The block then shifts out one framed serial word: start bit, 4 data bits LSB first, parity bit, stop bit. It also reports busy, done, an all-ones match flag and a running frame count. It is the sending end for the slot's 4-input all-ones detector, which asserts only when the received word equals 4'hF.

## Interface
Parameters:
- BIT_CYCLES, default 4: clock cycles per serial bit; legal range 1..255.

Ports (the slot uses only io_in and io_out; the bit fields are listed below, clock and reset first):
- io_in[0]  input  1  clk; the single clock, rising edge.
- io_in[1]  input  1  rst_n; reset is asynchronous and active-low.
- io_in[5:2]  input  4  data; the word to send.
- io_in[6]  input  1  start; level, sampled only in IDLE.
- io_in[7]  input  1  odd_sel; 0 selects even parity, 1 selects odd parity.
- io_out[0]  output  1  tx; serial line, idles high.
- io_out[1]  output  1  busy.
- io_out[2]  output  1  done; one-cycle pulse.
- io_out[3]  output  1  match; high when the latched word equals 4'hF.
- io_out[7:4]  output  4  frame_cnt; count of completed frames, wraps.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Bit period: one down-counter of width clog2(BIT_CYCLES+1) runs in every non-IDLE state. Each state lasts exactly BIT_CYCLES cycles.
- IDLE, start=1 at a rising edge:
  - Latch data into the shift register.
  - Latch the parity bit, computed as (^data) ^ odd_sel.
  - Update match from the latched data.
  - Next state is START.
- IDLE, start=0: stay in IDLE; tx=1.
- START: tx=0.
- DATA: tx = shift register bit 0. Shift right at each bit-period end. Bit index 0..3; leave DATA after bit 3.
- PARITY: tx = latched parity bit.
- STOP: tx=1. At the period end:
  - Return to IDLE.
  - Pulse done for one cycle, coincident with the first IDLE cycle.
  - Increment frame_cnt modulo 16 (15 -> 0).
- busy=1 in every non-IDLE state.
- start while busy: ignored; no queueing.
- start held high continuously: frames repeat back to back with exactly one IDLE cycle between them. That IDLE cycle is the one in which done=1 and start is resampled.
- Inputs change mid-frame: no effect. Data, odd_sel and match stay at the values latched at the frame start.
- Reset (asynchronous, any state): tx=1, busy=0, done=0, match=0, frame_cnt=0, state=IDLE, counters cleared. A partial frame is abandoned. No done pulse is generated and frame_cnt does not increment for it.
- All outputs are registered; no combinational path runs from io_in to io_out.

## Timing
- Start sampled at edge k: tx falls at edge k+1.
- Frame length: 7*BIT_CYCLES cycles, from edge k+1 to edge k+1+7*BIT_CYCLES.
- done and busy: at edge k+1+7*BIT_CYCLES, done rises and busy falls.
- Bit n of the frame (n=0 is the start bit) occupies edges k+1+n*BIT_CYCLES through k+(n+1)*BIT_CYCLES.
- BIT_CYCLES=1: 7-cycle frame. Back-to-back repetition period is 8 cycles.
- match is valid from edge k+1 and holds until the next frame start or reset.

## Structure
- Shared package tt_frame_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - FRAME_BITS=7, DATA_BITS=4.
  - Pin index constants for every io_in/io_out field above.
- One sub-module, tt_bit_timer: a BIT_CYCLES down-counter with load and tick output, instantiated once.
- The top-level holds the FSM, the shift register, the parity/match latches and frame_cnt.

## Test plan
Scenarios 1 to 4 use BIT_CYCLES=4.
1. Reset check: assert rst_n=0 mid-DATA, asynchronously between edges -> tx=1, busy=0, done=0, match=0 and frame_cnt=0 immediately. After release, stay IDLE until start.
2. Even-parity frame: data=4'hA, odd_sel=0, single start pulse -> tx carries 0,0,1,0,1,0,1, each held 4 cycles (28 cycles). Then done=1 for one cycle, frame_cnt=1, match=0.
3. Odd-parity all-ones frame: data=4'hF, odd_sel=1 -> tx carries 0,1,1,1,1,1,1 with parity bit 1, and match=1 from the cycle after start.
4. Start held high for 16 frames -> busy drops for exactly one cycle between frames. frame_cnt goes 1..15 then wraps to 0. There are 16 done pulses, spaced 29 cycles apart.
5. Mid-frame changes with BIT_CYCLES=1: change data and odd_sel, and pulse start, during the frame -> the 7-cycle frame is unchanged and no extra frame is sent.

Source files
------------

// File: rtl/tt_frame_pkg.sv
// Shared definitions for the TinyTapeout frame transmitter.
// Holds the state codes, the frame geometry and the io_in/io_out pin map.
package tt_frame_pkg;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  // State codes, kept as plain constants so older tools accept them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int PIN_CLK     = 0;
  localparam int PIN_RST_N   = 1;
  localparam int PIN_DATA    = 2;
  localparam int PIN_START   = 6;
  localparam int PIN_ODD_SEL = 7;

  localparam int PIN_TX    = 0;
  localparam int PIN_BUSY  = 1;
  localparam int PIN_DONE  = 2;
  localparam int PIN_MATCH = 3;
  localparam int PIN_CNT   = 4;

endpackage

// File: rtl/tt_bit_timer.sv
// Bit-period down-counter: load restarts a period of BIT_CYCLES cycles,
// and tick is high during the last cycle of the period.
module tt_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int unsigned W = $clog2(BIT_CYCLES + 1);
  localparam logic [W-1:0] RELOAD = W'(BIT_CYCLES - 1);

  logic [W-1:0] count;

  // The counter rests at zero while the transmitter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/tt_frame_tx.sv
// Serial frame transmitter for a TinyTapeout slot: start bit, 4 data bits
// LSB first, parity bit, stop bit, plus busy/done/match/frame count.
module tt_frame_tx
  import tt_frame_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 odd_sel;
  logic [DATA_BITS-1:0] data;

  assign clk     = io_in[PIN_CLK];
  assign rst_n   = io_in[PIN_RST_N];
  assign data    = io_in[PIN_DATA +: DATA_BITS];
  assign start   = io_in[PIN_START];
  assign odd_sel = io_in[PIN_ODD_SEL];

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic                 parity;
  logic [1:0]           bit_idx;
  logic                 frame_end;
  logic                 load;
  logic                 tick;
  logic                 tx_next;

  logic       tx;
  logic       busy;
  logic       done;
  logic       match;
  logic [3:0] frame_cnt;

  tt_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  always_comb begin
    load = 1'b0;
    if (state == ST_IDLE) begin
      load = start;
    end else if (tick && state != ST_STOP) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift     <= '0;
      parity    <= 1'b0;
      bit_idx   <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift   <= data;
            parity  <= (^data) ^ odd_sel;
            bit_idx <= '0;
            state   <= ST_START;
          end
        end
        ST_START: if (tick) state <= ST_DATA;
        ST_DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 2'(DATA_BITS - 1)) state <= ST_PARITY;
          end
        end
        ST_PARITY: if (tick) state <= ST_STOP;
        ST_STOP: begin
          if (tick) begin
            state     <= ST_IDLE;
            frame_end <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift[0];
      ST_PARITY: tx_next = parity;
      default:   tx_next = 1'b1;
    endcase
  end

  // Outputs trail the FSM by one cycle so every pin comes straight from a flop;
  // match is taken during START, once the word is latched and before shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      tx   <= tx_next;
      busy <= (state != ST_IDLE);
      done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      if (state == ST_START) match <= &shift;
    end
  end

  assign io_out[PIN_TX]        = tx;
  assign io_out[PIN_BUSY]      = busy;
  assign io_out[PIN_DONE]      = done;
  assign io_out[PIN_MATCH]     = match;
  assign io_out[PIN_CNT +: 4]  = frame_cnt;

endmodule

// File: tb/tb_tt_frame_tx.sv
// Bench for tt_frame_tx: a timeline model of the serial frame checked every
// cycle against a BIT_CYCLES=4 and a BIT_CYCLES=1 instance, plus literal checks.
module tb_tt_frame_tx;
  import tt_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_v [2];
  logic [3:0] data_v  [2];
  logic       odd_v   [2];
  logic [7:0] io_in_a, io_in_b, io_out_a, io_out_b;

  int   total = 0;
  int   bad = 0;
  int   cur_t = 0;
  logic cmp_en = 1'b0;

  // Expected-output model state, one slot per instance (0: BIT_CYCLES=4, 1: BIT_CYCLES=1).
  logic       m_active [2];
  int         m_t      [2];
  logic [6:0] m_bits   [2];
  logic       m_word   [2];
  logic       e_tx     [2];
  logic       e_busy   [2];
  logic       e_done   [2];
  logic       e_match  [2];
  logic [3:0] e_cnt    [2];

  always #5 clk = ~clk;

  assign io_in_a = {odd_v[0], start_v[0], data_v[0], rst_n, clk};
  assign io_in_b = {odd_v[1], start_v[1], data_v[1], rst_n, clk};

  tt_frame_tx #(.BIT_CYCLES(4)) dut4 (.io_in(io_in_a), .io_out(io_out_a));
  tt_frame_tx #(.BIT_CYCLES(1)) dut1 (.io_in(io_in_b), .io_out(io_out_b));

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] data, input logic odd, input logic st);
    data_v[d]  = data;
    odd_v[d]   = odd;
    start_v[d] = st;
  endtask

  task automatic stepTo(input int target);
    while (cur_t < target) begin
      @(negedge clk);
      cur_t++;
    end
  endtask

  // A frame accepted at edge k drives bit n for the BIT_CYCLES edges after
  // k+n*B, then done/busy-low/count-up land on edge k+7B+1, where start is resampled.
  always @(posedge clk or negedge rst_n) begin : model
    int   b;
    int   t;
    logic act;
    logic par;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_active[d] <= 1'b0;
        m_t[d]      <= 0;
        m_bits[d]   <= '0;
        m_word[d]   <= 1'b0;
        e_tx[d]     <= 1'b1;
        e_busy[d]   <= 1'b0;
        e_done[d]   <= 1'b0;
        e_match[d]  <= 1'b0;
        e_cnt[d]    <= 4'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        b   = (d == 0) ? 4 : 1;
        act = m_active[d];
        t   = m_t[d] + 1;
        if (act && t <= 7 * b) begin
          e_tx[d]   <= m_bits[d][(t - 1) / b];
          e_busy[d] <= 1'b1;
          e_done[d] <= 1'b0;
          if (t == 1) e_match[d] <= m_word[d];
        end else if (act) begin
          e_tx[d]   <= 1'b1;
          e_busy[d] <= 1'b0;
          e_done[d] <= 1'b1;
          e_cnt[d]  <= e_cnt[d] + 4'd1;
          act = 1'b0;
        end else begin
          e_tx[d]   <= 1'b1;
          e_busy[d] <= 1'b0;
          e_done[d] <= 1'b0;
        end
        m_t[d] <= t;
        if (!act && start_v[d]) begin
          par = (($countones(data_v[d]) % 2) == 1) ^ odd_v[d];
          m_active[d] <= 1'b1;
          m_t[d]      <= 0;
          m_bits[d]   <= {1'b1, par, data_v[d], 1'b0};
          m_word[d]   <= (data_v[d] == 4'hF);
        end else begin
          m_active[d] <= act;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] o;
        o = (d == 0) ? io_out_a : io_out_b;
        checkOutput($sformatf("d%0d_tx", d),    int'(o[PIN_TX]),      int'(e_tx[d]));
        checkOutput($sformatf("d%0d_busy", d),  int'(o[PIN_BUSY]),    int'(e_busy[d]));
        checkOutput($sformatf("d%0d_done", d),  int'(o[PIN_DONE]),    int'(e_done[d]));
        checkOutput($sformatf("d%0d_match", d), int'(o[PIN_MATCH]),   int'(e_match[d]));
        checkOutput($sformatf("d%0d_cnt", d),   int'(o[PIN_CNT +: 4]), int'(e_cnt[d]));
      end
    end
  end

  initial begin
    logic [6:0] s2_bits;
    logic [6:0] s3_bits;
    logic [6:0] s5_bits;
    int pulses;
    int cyc;
    int last_cyc;
    s2_bits = 7'b1010100;
    s3_bits = 7'b1111110;
    s5_bits = 7'b1101100;
    for (int d = 0; d < 2; d++) applyStimulus(d, 4'h0, 1'b0, 1'b0);

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("init_tx", int'(io_out_a[PIN_TX]), 1);
    checkOutput("init_busy", int'(io_out_a[PIN_BUSY]), 0);

    $display("[TB] even parity frame, data=A");
    applyStimulus(0, 4'hA, 1'b0, 1'b1);
    @(negedge clk);
    cur_t = 0;
    applyStimulus(0, 4'hA, 1'b0, 1'b0);
    for (int n = 0; n < 7; n++) begin
      stepTo(n * 4 + 2);
      checkOutput("s2_bit", int'(io_out_a[PIN_TX]), int'(s2_bits[n]));
    end
    stepTo(29);
    checkOutput("s2_done", int'(io_out_a[PIN_DONE]), 1);
    checkOutput("s2_busy", int'(io_out_a[PIN_BUSY]), 0);
    checkOutput("s2_cnt", int'(io_out_a[PIN_CNT +: 4]), 1);
    checkOutput("s2_match", int'(io_out_a[PIN_MATCH]), 0);
    stepTo(30);
    checkOutput("s2_done_end", int'(io_out_a[PIN_DONE]), 0);

    $display("[TB] odd parity all-ones frame");
    applyStimulus(0, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    cur_t = 0;
    applyStimulus(0, 4'hF, 1'b1, 1'b0);
    stepTo(1);
    checkOutput("s3_match", int'(io_out_a[PIN_MATCH]), 1);
    for (int n = 0; n < 7; n++) begin
      stepTo(n * 4 + 2);
      checkOutput("s3_bit", int'(io_out_a[PIN_TX]), int'(s3_bits[n]));
    end
    stepTo(29);
    checkOutput("s3_done", int'(io_out_a[PIN_DONE]), 1);
    checkOutput("s3_cnt", int'(io_out_a[PIN_CNT +: 4]), 2);
    checkOutput("s3_match_hold", int'(io_out_a[PIN_MATCH]), 1);

    $display("[TB] asynchronous reset mid-frame");
    @(negedge clk);
    applyStimulus(0, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    cur_t = 0;
    applyStimulus(0, 4'hF, 1'b0, 1'b0);
    stepTo(10);
    checkOutput("s1_busy_pre", int'(io_out_a[PIN_BUSY]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s1_tx", int'(io_out_a[PIN_TX]), 1);
    checkOutput("s1_busy", int'(io_out_a[PIN_BUSY]), 0);
    checkOutput("s1_done", int'(io_out_a[PIN_DONE]), 0);
    checkOutput("s1_match", int'(io_out_a[PIN_MATCH]), 0);
    checkOutput("s1_cnt", int'(io_out_a[PIN_CNT +: 4]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("s1_idle_busy", int'(io_out_a[PIN_BUSY]), 0);
    checkOutput("s1_idle_cnt", int'(io_out_a[PIN_CNT +: 4]), 0);

    $display("[TB] start held for 16 frames");
    pulses = 0;
    cyc = 0;
    last_cyc = 0;
    applyStimulus(0, 4'h3, 1'b0, 1'b1);
    while (pulses < 16 && cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (io_out_a[PIN_DONE]) begin
        pulses++;
        checkOutput("s4_cnt", int'(io_out_a[PIN_CNT +: 4]), pulses % 16);
        if (pulses > 1) checkOutput("s4_gap", cyc - last_cyc, 29);
        last_cyc = cyc;
        if (pulses == 15) applyStimulus(0, 4'h3, 1'b0, 1'b0);
      end
    end
    checkOutput("s4_pulses", pulses, 16);
    repeat (40) @(negedge clk);
    checkOutput("s4_idle_busy", int'(io_out_a[PIN_BUSY]), 0);

    $display("[TB] mid-frame input changes, BIT_CYCLES=1");
    applyStimulus(1, 4'h6, 1'b1, 1'b1);
    @(negedge clk);
    cur_t = 0;
    applyStimulus(1, 4'h6, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) begin
      stepTo(n + 1);
      if (n == 1) applyStimulus(1, 4'h9, 1'b0, 1'b1);
      if (n == 3) applyStimulus(1, 4'h9, 1'b0, 1'b0);
      checkOutput("s5_bit", int'(io_out_b[PIN_TX]), int'(s5_bits[n]));
    end
    stepTo(8);
    checkOutput("s5_done", int'(io_out_b[PIN_DONE]), 1);
    checkOutput("s5_cnt", int'(io_out_b[PIN_CNT +: 4]), 1);
    stepTo(18);
    checkOutput("s5_no_extra", int'(io_out_b[PIN_BUSY]), 0);
    checkOutput("s5_cnt_hold", int'(io_out_b[PIN_CNT +: 4]), 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
